// File: rtl/trap_sequencer.sv
// trap_sequencer: trap/return redirect stage downstream of the CSR file.
// On an accepted ECALL or MRET in execute it flushes younger instructions and
// holds fetch/decode. It then drains for DRAIN_CYCLES cycles so the CSR writes
// can settle, and finally issues a valid/ready redirect to mtvec or mepc.
// Optional feature macro: TRAP_SEQ_STATS_EN adds the trap_cnt accept counter.
//
// Handshake: redir_valid/redir_pc form a valid/ready pair with fe_ready.
// Once redir_valid is raised, it and redir_pc stay constant until a rising
// edge where fe_ready=1. That edge completes the transfer and returns to IDLE.
// The completing edge never accepts a new trap.
module trap_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_ir,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        fe_ready,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic        flush,
    output logic        hold,
`ifdef TRAP_SEQ_STATS_EN
    output logic [31:0] trap_cnt,
`endif
    output logic [31:0] dbg_trap_pc,
    output logic [1:0]  state_dbg
);

    localparam logic [31:0] ECALL_ENC = 32'h0000_0073;
    localparam logic [31:0] MRET_ENC  = 32'h3020_0073;

    // A drain of zero cycles would collapse DRAIN into the accept edge.
    // A count above 15 does not fit the 4-bit drain counter.
    if ((DRAIN_CYCLES < 1) || (DRAIN_CYCLES > 15)) begin : g_bad_drain
        $error("trap_sequencer: DRAIN_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        kind, kind_nxt;     // 1 = MRET, 0 = ECALL
    logic        load_pc;
    logic        flush_q;
    logic [31:0] redir_pc_q;
    logic [31:0] dbg_pc_q;

    logic is_ecall, is_mret, accept;
    assign is_ecall = (ex_ir == ECALL_ENC);
    assign is_mret  = (ex_ir == MRET_ENC);
    assign accept   = (state == IDLE) && ex_valid && (is_ecall || is_mret);

    // The low bits of mtvec hold the vector mode and are masked off the target.
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec[1:0];

    // State register, drain counter and recorded event kind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            kind  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            kind  <= kind_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in DRAIN, then wait for fetch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        kind_nxt  = kind;
        load_pc   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = 4'(DRAIN_CYCLES - 1);
                    kind_nxt  = is_mret;
                end
            end
            DRAIN: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = REDIR;
                    load_pc   = 1'b1;
                end
            end
            REDIR: begin
                if (fe_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Flush pulse covers exactly the cycle after the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flush_q <= 1'b0;
        else        flush_q <= accept;
    end

    // Redirect target is sampled once, when DRAIN hands over to REDIR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       redir_pc_q <= 32'h0;
        else if (load_pc) redir_pc_q <= kind ? mepc : {mtvec[31:2], 2'b00};
    end

    // PC of the trapping instruction, kept for debug only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dbg_pc_q <= 32'h0;
        else if (accept) dbg_pc_q <= ex_pc;
    end

`ifdef TRAP_SEQ_STATS_EN
    logic [31:0] trap_cnt_q;

    // Accepted-event counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      trap_cnt_q <= 32'h0;
        else if (accept) trap_cnt_q <= trap_cnt_q + 32'd1;
    end

    assign trap_cnt = trap_cnt_q;
`endif

    assign redir_valid = (state == REDIR);
    assign redir_pc    = redir_pc_q;
    assign flush       = flush_q;
    assign hold        = (state != IDLE);
    assign dbg_trap_pc = dbg_pc_q;
    assign state_dbg   = state;

endmodule
